mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM pipeline stage between EX_MEM and MEM_WB. Consumes EX_MEM outputs, runs
//  loads/stores against a variable-latency data memory (req/ack), holds the
//  pipeline via StallOut, and forms the final writeback word (load/ALU/HI/LO).
//  Includes movn/movz suppression and a wait watchdog. Outputs are registered.
// PARAMETERS
//  MAX_WAIT  255  cycles in WAIT before the watchdog aborts the access (1..65535)
//  CNT_W     16   width of the wait counter; must hold MAX_WAIT
// PORTS
//  Clk            in   1   clock; all state updates on negedge Clk (pipeline convention)
//  Rst_n          in   1   synchronous active-low reset, sampled on negedge Clk
//  ValidIn        in   1   EX_MEM slot holds a live instruction
//  RegWriteIn, MemToRegIn, HiLoToRegIn, HiOrLoIn, MemReadIn, MemWriteIn  in 1 EX_MEM controls
//  MoveNotZeroIn, DontMoveIn, LbIn, LoadExtendedIn                      in 1 EX_MEM controls
//  ALUResultIn    in   32  ALU result / memory byte address
//  RD2In          in   32  store data
//  RHiIn, RLoIn   in   32  HI / LO values
//  WriteAddressIn in   5   destination register
//  DmReq          out  1   memory request, held until DmAck
//  DmWe           out  1   1 = store
//  DmAddr         out  32  word address ({addr[31:2],2'b00})
//  DmWData        out  32  store data
//  DmAck          in   1   access complete; DmRData valid same cycle
//  DmRData        in   32  read data
//  StallOut       out  1   freeze EX_MEM and earlier stages
//  ValidOut, RegWriteOut  out 1; WriteAddressOut out 5; WriteDataOut out 32; ErrOut out 1
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, every output 0 (DmReq, StallOut, ValidOut, ErrOut incl.).
//  FSM IDLE: ValidIn & ~(MemReadIn|MemWriteIn) -> result registered next edge, ValidOut=1
//    for one cycle (latency 1). ValidIn & (MemReadIn|MemWriteIn) -> capture addr/data/
//    controls, go WAIT, DmReq=1; StallOut asserted combinationally in that cycle.
//    ValidIn=0 -> ValidOut=0, RegWriteOut=0.
//  WAIT: DmReq/DmWe/DmAddr/DmWData stable; StallOut=1; counter++ each edge.
//    DmAck -> DONE: DmReq drops, load data latched; next edge ValidOut=1, state IDLE.
//    StallOut falls in DONE cycle so EX_MEM advances exactly once.
//    counter==MAX_WAIT & ~DmAck -> abort: DmReq=0, ValidOut=1, RegWriteOut=0, ErrOut=1
//    for one cycle, return IDLE. DmAck in the same cycle as timeout wins (no error).
//  Store: DmWe=1; ValidOut=1 after ack with RegWriteOut=0. Word stores only.
//  Load word: WriteDataOut=DmRData. LbIn: byte lane addr[1:0] (lane 0 = bits 7:0,
//    little-endian); LoadExtendedIn=1 sign-extends bit 7, else zero-extends.
//  Write data mux: MemToReg -> load; else HiLoToReg -> (HiOrLo ? RHi : RLo); else ALUResult.
//  RegWriteOut = RegWriteIn & ~(MoveNotZeroIn & DontMoveIn) & ValidIn (captured values).
//  Rst_n low in WAIT/DONE: drop DmReq immediately at that edge, discard result, IDLE.
//  Back-to-back memory ops: second accepted in the IDLE cycle after DONE; no bubble
//  beyond the handshake; ALU ops in DONE cycle are not accepted (stalled).
// CONFIGURATION
//  ALIGN_CHECK_EN defined: word access with addr[1:0]!=0 is not issued; ValidOut=1,
//    RegWriteOut=0, ErrOut=1 next edge, FSM stays IDLE, DmReq never rises.
//  Undefined: address low bits ignored for word accesses (DmAddr forced aligned).
// STRUCTURE
//  Package mem_stage_pkg: state enum {IDLE,WAIT,DONE}, write-data select enum,
//  BYTE_W=8, WORD_W=32. Sub-module load_align (combinational byte select/extend)
//  instantiated once; FSM, counter and output register in top.
// TESTING
//  ALU op ALUResult=0x1234, RegWrite=1, WA=5 -> next edge ValidOut=1, WD=0x1234, WA=5.
//  lw addr 0x100, DmAck after 3 cycles, RData=0xDEADBEEF -> StallOut 4 cycles, WD=0xDEADBEEF.
//  lb addr 0x103, RData=0x80112233, LoadExtended=1 -> 0xFFFFFF80; =0 -> 0x00000080.
//  sw addr 0x200 data 0xCAFEF00D -> DmWe=1,DmAddr=0x200; after ack RegWriteOut=0.
//  movn with DontMove=1 -> RegWriteOut=0; HiLoToReg,HiOrLo=1,RHi=0x7 -> WD=0x7.
//  MAX_WAIT=4, no ack -> ErrOut pulse after 4 WAIT cycles; Rst_n low mid-WAIT -> DmReq=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: FSM states, write-data select and the captured
// EX_MEM slot that travels with an outstanding memory access.
package mem_stage_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  typedef enum logic [1:0] {SEL_ALU, SEL_LOAD, SEL_HI, SEL_LO} wsel_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic              hilo_to_reg;
    logic              hi_or_lo;
    logic              lb;
    logic              load_ext;
    logic [4:0]        wa;
    logic [WORD_W-1:0] alu;
    logic [WORD_W-1:0] rhi;
    logic [WORD_W-1:0] rlo;
  } slot_t;

  function automatic wsel_t write_sel(input logic mem_to_reg, input logic hilo_to_reg,
                                      input logic hi_or_lo);
    if (mem_to_reg)       return SEL_LOAD;
    else if (hilo_to_reg) return hi_or_lo ? SEL_HI : SEL_LO;
    else                  return SEL_ALU;
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Combinational load formatter: passes the word through, or selects one
// little-endian byte lane and sign/zero-extends it for byte loads.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        lane,
  input  logic              byte_en,
  input  logic              sign_ext,
  output logic [WORD_W-1:0] data
);

  logic [BYTE_W-1:0] sel_byte;

  always_comb begin
    sel_byte = word[BYTE_W-1:0];
    case (lane)
      2'd1:    sel_byte = word[2*BYTE_W-1:BYTE_W];
      2'd2:    sel_byte = word[3*BYTE_W-1:2*BYTE_W];
      2'd3:    sel_byte = word[4*BYTE_W-1:3*BYTE_W];
      default: sel_byte = word[BYTE_W-1:0];
    endcase
    if (byte_en)
      data = {{(WORD_W-BYTE_W){sign_ext & sel_byte[BYTE_W-1]}}, sel_byte};
    else
      data = word;
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: req/ack data-memory access with stall, watchdog and writeback mux.
// Optional build macro ALIGN_CHECK_EN rejects misaligned word accesses with ErrOut.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              ValidIn,
  input  logic              RegWriteIn,
  input  logic              MemToRegIn,
  input  logic              HiLoToRegIn,
  input  logic              HiOrLoIn,
  input  logic              MemReadIn,
  input  logic              MemWriteIn,
  input  logic              MoveNotZeroIn,
  input  logic              DontMoveIn,
  input  logic              LbIn,
  input  logic              LoadExtendedIn,
  input  logic [WORD_W-1:0] ALUResultIn,
  input  logic [WORD_W-1:0] RD2In,
  input  logic [WORD_W-1:0] RHiIn,
  input  logic [WORD_W-1:0] RLoIn,
  input  logic [4:0]        WriteAddressIn,
  output logic              DmReq,
  output logic              DmWe,
  output logic [WORD_W-1:0] DmAddr,
  output logic [WORD_W-1:0] DmWData,
  input  logic              DmAck,
  input  logic [WORD_W-1:0] DmRData,
  output logic              StallOut,
  output logic              ValidOut,
  output logic              RegWriteOut,
  output logic [4:0]        WriteAddressOut,
  output logic [WORD_W-1:0] WriteDataOut,
  output logic              ErrOut
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  slot_t             slot_in;
  slot_t             slot_p1;
  logic [WORD_W-1:0] ld_word_p2;
  logic [WORD_W-1:0] ld_data;
  logic              mem_op;
  logic              misalign;
  logic              issue;
  logic              timeout;

  function automatic logic [WORD_W-1:0] wdata(input slot_t s, input logic [WORD_W-1:0] ld);
    case (write_sel(s.mem_to_reg, s.hilo_to_reg, s.hi_or_lo))
      SEL_LOAD: return ld;
      SEL_HI:   return s.rhi;
      SEL_LO:   return s.rlo;
      default:  return s.alu;
    endcase
  endfunction

  // Stores never write the register file; a suppressed movn/movz does not either.
  always_comb begin
    slot_in             = '0;
    slot_in.reg_write   = ValidIn & RegWriteIn & ~(MoveNotZeroIn & DontMoveIn) & ~MemWriteIn;
    slot_in.mem_to_reg  = MemToRegIn;
    slot_in.hilo_to_reg = HiLoToRegIn;
    slot_in.hi_or_lo    = HiOrLoIn;
    slot_in.lb          = LbIn;
    slot_in.load_ext    = LoadExtendedIn;
    slot_in.wa          = WriteAddressIn;
    slot_in.alu         = ALUResultIn;
    slot_in.rhi         = RHiIn;
    slot_in.rlo         = RLoIn;
  end

  assign mem_op = ValidIn & (MemReadIn | MemWriteIn);

`ifdef ALIGN_CHECK_EN
  assign misalign = mem_op & ~(MemReadIn & LbIn) & (ALUResultIn[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign issue   = (state == IDLE) & mem_op & ~misalign;
  assign timeout = (state == WAIT) & (cnt == CNT_W'(MAX_WAIT)) & ~DmAck;

  // Stall drops in the abort cycle too, so the aborted instruction leaves EX_MEM once.
  assign StallOut = issue | ((state == WAIT) & ~timeout);

  load_align u_load_align (
    .word     (ld_word_p2),
    .lane     (slot_p1.alu[1:0]),
    .byte_en  (slot_p1.lb),
    .sign_ext (slot_p1.load_ext),
    .data     (ld_data)
  );

  // p1: capture of the accepted memory instruction; p2: returned load word
  always_ff @(negedge Clk) begin
    if (issue) slot_p1 <= slot_in;
    if ((state == WAIT) && DmAck) ld_word_p2 <= DmRData;
  end

  // Control FSM, wait counter and registered stage outputs
  always_ff @(negedge Clk) begin
    if (!Rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      DmReq           <= 1'b0;
      DmWe            <= 1'b0;
      DmAddr          <= '0;
      DmWData         <= '0;
      ValidOut        <= 1'b0;
      RegWriteOut     <= 1'b0;
      WriteAddressOut <= '0;
      WriteDataOut    <= '0;
      ErrOut          <= 1'b0;
    end else begin
      ValidOut    <= 1'b0;
      RegWriteOut <= 1'b0;
      ErrOut      <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (issue) begin
            state   <= WAIT;
            cnt     <= CNT_W'(1);
            DmReq   <= 1'b1;
            DmWe    <= MemWriteIn;
            DmAddr  <= {ALUResultIn[WORD_W-1:2], 2'b00};
            DmWData <= RD2In;
          end else if (ValidIn) begin
            ValidOut        <= 1'b1;
            RegWriteOut     <= slot_in.reg_write & ~misalign;
            ErrOut          <= misalign;
            WriteAddressOut <= WriteAddressIn;
            WriteDataOut    <= wdata(slot_in, ld_data);
          end
        end
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (DmAck) begin
            state <= DONE;
            DmReq <= 1'b0;
            DmWe  <= 1'b0;
          end else if (timeout) begin
            state           <= IDLE;
            DmReq           <= 1'b0;
            DmWe            <= 1'b0;
            ValidOut        <= 1'b1;
            ErrOut          <= 1'b1;
            WriteAddressOut <= slot_p1.wa;
          end
        end
        DONE: begin
          state           <= IDLE;
          cnt             <= '0;
          ValidOut        <= 1'b1;
          RegWriteOut     <= slot_p1.reg_write;
          WriteAddressOut <= slot_p1.wa;
          WriteDataOut    <= wdata(slot_p1, ld_data);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized
// instruction streams against a transaction-level reference model.
module tb_mem_access_stage;

  localparam int MW = 4;

  typedef struct {
    logic        rw, m2r, hilo, hiorlo, mr, mw, movn, dont, lb, ext;
    logic [31:0] alu, rd2, rhi, rlo;
    logic [4:0]  wa;
  } instr_t;

  logic        Clk = 1'b1;
  logic        Rst_n = 1'b0;
  logic        ValidIn = 1'b0, RegWriteIn = 1'b0, MemToRegIn = 1'b0, HiLoToRegIn = 1'b0;
  logic        HiOrLoIn = 1'b0, MemReadIn = 1'b0, MemWriteIn = 1'b0, MoveNotZeroIn = 1'b0;
  logic        DontMoveIn = 1'b0, LbIn = 1'b0, LoadExtendedIn = 1'b0;
  logic [31:0] ALUResultIn = '0, RD2In = '0, RHiIn = '0, RLoIn = '0;
  logic [4:0]  WriteAddressIn = '0;
  logic        DmReq, DmWe, DmAck = 1'b0;
  logic [31:0] DmAddr, DmWData, DmRData = '0;
  logic        StallOut, ValidOut, RegWriteOut, ErrOut;
  logic [4:0]  WriteAddressOut;
  logic [31:0] WriteDataOut;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_stage #(.MAX_WAIT(MW), .CNT_W(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ValidIn(ValidIn), .RegWriteIn(RegWriteIn),
    .MemToRegIn(MemToRegIn), .HiLoToRegIn(HiLoToRegIn), .HiOrLoIn(HiOrLoIn),
    .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn), .MoveNotZeroIn(MoveNotZeroIn),
    .DontMoveIn(DontMoveIn), .LbIn(LbIn), .LoadExtendedIn(LoadExtendedIn),
    .ALUResultIn(ALUResultIn), .RD2In(RD2In), .RHiIn(RHiIn), .RLoIn(RLoIn),
    .WriteAddressIn(WriteAddressIn), .DmReq(DmReq), .DmWe(DmWe), .DmAddr(DmAddr),
    .DmWData(DmWData), .DmAck(DmAck), .DmRData(DmRData), .StallOut(StallOut),
    .ValidOut(ValidOut), .RegWriteOut(RegWriteOut), .WriteAddressOut(WriteAddressOut),
    .WriteDataOut(WriteDataOut), .ErrOut(ErrOut)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: result word and register-write decision from the instruction alone.
  function automatic logic [31:0] exp_wd(input instr_t i, input logic [31:0] rdata);
    logic [31:0] ld;
    int          b;
    b = int'((rdata >> (8 * int'(i.alu[1:0]))) & 32'hFF);
    if (!i.lb)                 ld = rdata;
    else if (i.ext && b > 127) ld = 32'(b - 256);
    else                       ld = 32'(b);
    if (i.m2r)  return ld;
    if (i.hilo) return i.hiorlo ? i.rhi : i.rlo;
    return i.alu;
  endfunction

  function automatic logic exp_rw(input instr_t i);
    return i.rw && !(i.movn && i.dont) && !i.mw;
  endfunction

  function automatic instr_t rand_instr(input int kind);
    instr_t i;
    i.rw = 1'($urandom); i.movn = 1'($urandom); i.dont = 1'($urandom);
    i.hilo = 1'($urandom); i.hiorlo = 1'($urandom);
    i.m2r = 1'b0; i.mr = 1'b0; i.mw = 1'b0; i.lb = 1'b0; i.ext = 1'($urandom);
    i.alu = $urandom; i.rd2 = $urandom; i.rhi = $urandom; i.rlo = $urandom;
    i.wa = 5'($urandom);
    if (kind == 1 || kind == 2) begin
      i.mr = 1'b1; i.m2r = 1'b1; i.lb = (kind == 2);
    end else if (kind == 3) begin
      i.mw = 1'b1;
    end
    return i;
  endfunction

  task automatic drive(input instr_t i);
    ValidIn = 1'b1; RegWriteIn = i.rw; MemToRegIn = i.m2r; HiLoToRegIn = i.hilo;
    HiOrLoIn = i.hiorlo; MemReadIn = i.mr; MemWriteIn = i.mw; MoveNotZeroIn = i.movn;
    DontMoveIn = i.dont; LbIn = i.lb; LoadExtendedIn = i.ext; ALUResultIn = i.alu;
    RD2In = i.rd2; RHiIn = i.rhi; RLoIn = i.rlo; WriteAddressIn = i.wa;
  endtask

  task automatic idle_cycle();
    ValidIn = 1'b0; MemReadIn = 1'b0; MemWriteIn = 1'b0;
    #1;
    check_eq("idle_stall", StallOut, 0);
    @(negedge Clk); #1;
    check_eq("idle_valid", ValidOut, 0);
    check_eq("idle_regwrite", RegWriteOut, 0);
  endtask

  // Entered 1 time unit after an active edge; returns at the same phase.
  task automatic run_alu(input instr_t i);
    drive(i);
    #1;
    check_eq("alu_stall", StallOut, 0);
    @(negedge Clk); #1;
    check_eq("alu_valid", ValidOut, 1);
    check_eq("alu_err", ErrOut, 0);
    check_eq("alu_regwrite", RegWriteOut, exp_rw(i));
    check_eq("alu_wa", WriteAddressOut, i.wa);
    check_eq("alu_wd", WriteDataOut, exp_wd(i, 32'h0));
  endtask

  // lat = cycle of DmReq in which ack is returned; outside 1..MW means never.
  task automatic run_mem(input instr_t i, input int lat, input logic [31:0] rdata);
    int stalls = 0, reqs = 0, edges = 0;
    bit seen = 0, tmo, rej;
    tmo = (lat < 1) || (lat > MW);
    rej = 1'b0;
`ifdef ALIGN_CHECK_EN
    rej = !(i.mr && i.lb) && (i.alu[1:0] != 2'b00);
`endif
    drive(i);
    while (!seen && edges < 20 + MW) begin
      DmAck = 1'b0;
      DmRData = $urandom;
      if (DmReq) begin
        reqs++;
        if (reqs == 1) begin
          check_eq("dm_addr", DmAddr, i.alu & 32'hFFFF_FFFC);
          check_eq("dm_we", DmWe, i.mw);
          if (i.mw) check_eq("dm_wdata", DmWData, i.rd2);
        end
        if (reqs == lat) begin
          DmAck = 1'b1;
          DmRData = rdata;
        end
      end
      #1;
      if (StallOut) stalls++;
      @(negedge Clk); #1;
      edges++;
      if (ValidOut) seen = 1;
    end
    DmAck = 1'b0;
    check_eq("mem_result_seen", 32'(seen), 1);
    if (rej) begin
      check_eq("rej_edges", edges, 1);
      check_eq("rej_stalls", stalls, 0);
      check_eq("rej_reqs", reqs, 0);
      check_eq("rej_err", ErrOut, 1);
      check_eq("rej_regwrite", RegWriteOut, 0);
    end else if (tmo) begin
      check_eq("tmo_edges", edges, MW + 1);
      check_eq("tmo_stalls", stalls, MW);
      check_eq("tmo_reqs", reqs, MW);
      check_eq("tmo_err", ErrOut, 1);
      check_eq("tmo_regwrite", RegWriteOut, 0);
      check_eq("tmo_dmreq", DmReq, 0);
    end else begin
      check_eq("mem_edges", edges, lat + 2);
      check_eq("mem_stalls", stalls, lat + 1);
      check_eq("mem_reqs", reqs, lat);
      check_eq("mem_err", ErrOut, 0);
      check_eq("mem_regwrite", RegWriteOut, exp_rw(i));
      check_eq("mem_wa", WriteAddressOut, i.wa);
      if (!i.mw) check_eq("mem_wd", WriteDataOut, exp_wd(i, rdata));
      check_eq("mem_dmreq", DmReq, 0);
    end
  endtask

  initial begin
    instr_t i;
    int     vcount;

    // Reset state
    @(negedge Clk); @(negedge Clk); #1;
    check_eq("rst_dmreq", DmReq, 0);
    check_eq("rst_dmwe", DmWe, 0);
    check_eq("rst_dmaddr", DmAddr, 0);
    check_eq("rst_dmwdata", DmWData, 0);
    check_eq("rst_stall", StallOut, 0);
    check_eq("rst_valid", ValidOut, 0);
    check_eq("rst_regwrite", RegWriteOut, 0);
    check_eq("rst_wa", WriteAddressOut, 0);
    check_eq("rst_wd", WriteDataOut, 0);
    check_eq("rst_err", ErrOut, 0);
    Rst_n = 1'b1;
    @(negedge Clk); #1;

    // Directed cases
    i = rand_instr(0);
    i.rw = 1; i.movn = 0; i.hilo = 0; i.alu = 32'h1234; i.wa = 5;
    run_alu(i);
    i = rand_instr(1); i.alu = 32'h100; i.rw = 1; i.movn = 0;
    run_mem(i, 3, 32'hDEADBEEF);
    i = rand_instr(2); i.alu = 32'h103; i.rw = 1; i.movn = 0; i.ext = 1;
    run_mem(i, 2, 32'h80112233);
    check_eq("lb_sext", WriteDataOut, 32'hFFFFFF80);
    i.ext = 0;
    run_mem(i, 1, 32'h80112233);
    check_eq("lb_zext", WriteDataOut, 32'h00000080);
    i = rand_instr(3); i.alu = 32'h200; i.rd2 = 32'hCAFEF00D; i.rw = 1;
    run_mem(i, 2, 32'h0);
    i = rand_instr(0); i.rw = 1; i.movn = 1; i.dont = 1;
    run_alu(i);
    i = rand_instr(0); i.rw = 1; i.movn = 0; i.hilo = 1; i.hiorlo = 1; i.rhi = 32'h7;
    run_alu(i);
    check_eq("hi_wd", WriteDataOut, 32'h7);
    i = rand_instr(1); i.alu = 32'h40;
    run_mem(i, 0, 32'h0);
    i = rand_instr(1); i.alu = 32'h44;
    run_mem(i, MW, 32'h5A5A_1234);
    idle_cycle();

    // Reset in the middle of a wait: request drops, result discarded
    i = rand_instr(1); i.alu = 32'h80;
    drive(i);
    @(negedge Clk); #1;
    check_eq("midrst_req_up", DmReq, 1);
    @(negedge Clk); #1;
    Rst_n = 1'b0; ValidIn = 1'b0; MemReadIn = 1'b0;
    @(negedge Clk); #1;
    check_eq("midrst_dmreq", DmReq, 0);
    check_eq("midrst_valid", ValidOut, 0);
    check_eq("midrst_stall", StallOut, 0);
    Rst_n = 1'b1;
    vcount = 0;
    for (int k = 0; k < 4; k++) begin
      DmAck = 1'b1;
      @(negedge Clk); #1;
      if (ValidOut || DmReq) vcount++;
    end
    DmAck = 1'b0;
    check_eq("midrst_discard", vcount, 0);

    // Randomized back-to-back streams with occasional bubbles
    for (int n = 0; n < 150; n++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      i = rand_instr(kind);
      if (kind == 0) run_alu(i);
      else run_mem(i, int'($urandom_range(0, MW + 1)), $urandom);
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
